// File: rtl/cpu_ctrl_fsm_if.sv
// Bus between the instruction sequencer, the instruction memory and the datapath.
// The controller connects through the master modport; memory and datapath use the slave side.
interface cpu_ctrl_fsm_if #(
    parameter int PC_W = 16
);
    logic [15:0]     Inst;
    logic            InstAck;
    logic            InstReq;
    logic [PC_W-1:0] PC;
    logic [4:0]      Flags;
    logic [3:0]      RdestRegLoc;
    logic [3:0]      RsrcRegLoc;
    logic [4:0]      OpCode;
    logic [15:0]     Imm;
    logic            Imm_s;
    logic            En;
    logic [4:0]      FlagReg;

    modport master (
        input  Inst, InstAck, Flags,
        output InstReq, PC, RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s, En, FlagReg
    );

    modport slave (
        output Inst, InstAck, Flags,
        input  InstReq, PC, RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s, En, FlagReg
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC, PC, decode and branch resolution.
// Optional macro CTRL_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
module cpu_ctrl_fsm #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    cpu_ctrl_fsm_if.master        bus
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0]           RetireCnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [4:0]      flag_reg_q, flag_reg_d;
    logic            inst_req_q, inst_req_d;
    logic            en_q, en_d;
`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0]     retire_cnt_q, retire_cnt_d;
`endif

    logic [3:0]      op;
    logic            is_reg;
    logic            is_imm;
    logic            is_alu;
    logic            is_bcond;
    logic [4:0]      dec_opcode;
    logic            alu_write;
    logic            cond_true;
    logic            br_taken;
    logic [PC_W-1:0] disp_pc;

    // Decode is a pure function of IR, so it holds steady from DECODE through EXEC.
    always_comb begin
        op         = ir_q[15:12];
        is_reg     = (op == 4'd0);
        is_imm     = (op >= 4'd1) && (op <= 4'd11);
        is_alu     = (op <= 4'd11);
        is_bcond   = (op == 4'd12);
        dec_opcode = 5'd0;
        if (is_reg) begin
            dec_opcode = {1'b0, ir_q[7:4]};
        end else if (is_imm) begin
            dec_opcode = {1'b0, op};
        end
        alu_write = is_alu && (dec_opcode != 5'b01011);
        disp_pc   = PC_W'($signed(ir_q[7:0]));
    end

    // Branch conditions look at the latched flags of an earlier instruction.
    always_comb begin
        cond_true = 1'b0;
        case (ir_q[11:8])
            4'b0000: cond_true = flag_reg_q[3];
            4'b0001: cond_true = !flag_reg_q[3];
            4'b0010: cond_true = flag_reg_q[0];
            4'b0011: cond_true = !flag_reg_q[0];
            4'b0110: cond_true = flag_reg_q[4];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
        br_taken = is_bcond && cond_true;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        flag_reg_d = flag_reg_q;
        inst_req_d = inst_req_q;
        en_d       = 1'b0;
`ifdef CTRL_RETIRE_CNT_EN
        retire_cnt_d = retire_cnt_q;
`endif
        case (state_q)
            S_FETCH: begin
                inst_req_d = 1'b1;
                if (inst_req_q && bus.InstAck) begin
                    ir_d       = bus.Inst;
                    inst_req_d = 1'b0;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                inst_req_d = 1'b0;
                en_d       = alu_write;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu) begin
                    flag_reg_d = bus.Flags;
                end
                pc_d       = br_taken ? (pc_q + disp_pc) : (pc_q + PC_W'(1));
                inst_req_d = 1'b1;
                state_d    = S_FETCH;
`ifdef CTRL_RETIRE_CNT_EN
                retire_cnt_d = retire_cnt_q + 16'd1;
`endif
            end
            default: begin
                inst_req_d = 1'b0;
                state_d    = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            flag_reg_q <= 5'd0;
            inst_req_q <= 1'b0;
            en_q       <= 1'b0;
`ifdef CTRL_RETIRE_CNT_EN
            retire_cnt_q <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flag_reg_q <= flag_reg_d;
            inst_req_q <= inst_req_d;
            en_q       <= en_d;
`ifdef CTRL_RETIRE_CNT_EN
            retire_cnt_q <= retire_cnt_d;
`endif
        end
    end

    assign bus.InstReq     = inst_req_q;
    assign bus.PC          = pc_q;
    assign bus.RdestRegLoc = ir_q[11:8];
    assign bus.RsrcRegLoc  = ir_q[3:0];
    assign bus.OpCode      = dec_opcode;
    assign bus.Imm         = {{8{ir_q[7]}}, ir_q[7:0]};
    assign bus.Imm_s       = is_imm;
    assign bus.FlagReg     = flag_reg_q;
    // A reset landing in EXEC must suppress the write that this edge would otherwise commit.
    assign bus.En          = en_q & ~Rst;
`ifdef CTRL_RETIRE_CNT_EN
    assign RetireCnt       = retire_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: a memory-side stimulus process queues hand-computed
// expectations per instruction and a monitor compares them as the FSM steps through each one.
module tb_cpu_ctrl_fsm;

    logic Clk;
    logic Rst;
`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] RetireCnt;
    int          retire_exp = 0;
`endif

    cpu_ctrl_fsm_if #(.PC_W(16)) bus ();

    cpu_ctrl_fsm #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .RetireCnt (RetireCnt)
`endif
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] next_pc;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic        chk_op;
        logic [4:0]  op;
        logic [15:0] imm;
        logic        imm_s;
        logic        en;
        logic [4:0]  flag_after;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Acts as instruction memory for one instruction and queues what the monitor should see.
    task automatic apply_stimulus(input logic [15:0] inst, input logic [4:0] flags, input int waits,
                                  input bit abort, input logic [15:0] pc, input logic [15:0] next_pc,
                                  input logic [3:0] rd, input logic [3:0] rs, input bit chk_op,
                                  input logic [4:0] op, input logic [15:0] imm, input bit imm_s,
                                  input bit en, input logic [4:0] flag_after);
        exp_t e;
        int   cnt = 0;
        while (bus.InstReq !== 1'b1 && cnt < 50) begin
            @(posedge Clk); #1;
            cnt++;
        end
        if (bus.InstReq !== 1'b1) begin
            check_output("instreq_timeout", {31'd0, bus.InstReq}, 32'd1);
            return;
        end
        repeat (waits) begin
            @(posedge Clk); #1;
        end
        e.pc = pc; e.next_pc = next_pc; e.rd = rd; e.rs = rs; e.chk_op = chk_op; e.op = op;
        e.imm = imm; e.imm_s = imm_s; e.en = en; e.flag_after = flag_after;
        exp_q.push_back(e);
        bus.Inst    = inst;
        bus.Flags   = flags;
        bus.InstAck = 1'b1;
        @(posedge Clk); #1;
        bus.InstAck = 1'b0;
        bus.Inst    = 16'hFFFF;
        @(posedge Clk); #1;
        if (abort) Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
`ifdef CTRL_RETIRE_CNT_EN
        if (abort) retire_exp = 0;
        else       retire_exp++;
`endif
    endtask

    // Monitor: 0 idle/fetch, 1 decode, 2 exec, 3 first cycle after exec.
    initial begin
        int   phase = 0;
        exp_t cur;
        forever begin
            @(negedge Clk);
            if (phase == 3) begin
                check_output("next_pc", {16'd0, bus.PC}, {16'd0, cur.next_pc});
                check_output("flag_reg", {27'd0, bus.FlagReg}, {27'd0, cur.flag_after});
                check_output("en_after_exec", {31'd0, bus.En}, 32'd0);
                phase = 0;
            end else if (phase == 0 && Rst === 1'b0) begin
                check_output("en_idle", {31'd0, bus.En}, 32'd0);
            end
            if (phase == 0 && bus.InstReq === 1'b1 && bus.InstAck === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_fetch", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check_output("fetch_pc", {16'd0, bus.PC}, {16'd0, cur.pc});
                    phase = 1;
                end
            end else if (phase == 1) begin
                check_output("dec_rdest", {28'd0, bus.RdestRegLoc}, {28'd0, cur.rd});
                check_output("dec_rsrc", {28'd0, bus.RsrcRegLoc}, {28'd0, cur.rs});
                check_output("dec_imm", {16'd0, bus.Imm}, {16'd0, cur.imm});
                if (cur.chk_op) begin
                    check_output("dec_opcode", {27'd0, bus.OpCode}, {27'd0, cur.op});
                    check_output("dec_imm_s", {31'd0, bus.Imm_s}, {31'd0, cur.imm_s});
                end
                check_output("dec_en", {31'd0, bus.En}, 32'd0);
                check_output("dec_instreq", {31'd0, bus.InstReq}, 32'd0);
                phase = 2;
            end else if (phase == 2) begin
                check_output("exec_en", {31'd0, bus.En}, {31'd0, cur.en});
                check_output("exec_instreq", {31'd0, bus.InstReq}, 32'd0);
                check_output("exec_rdest", {28'd0, bus.RdestRegLoc}, {28'd0, cur.rd});
                check_output("exec_pc", {16'd0, bus.PC}, {16'd0, cur.pc});
                phase = 3;
            end
        end
    end

    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst         = 1'b1;
        bus.Inst    = 16'h0000;
        bus.InstAck = 1'b0;
        bus.Flags   = 5'd0;
        repeat (2) @(posedge Clk);
        #1;
        check_output("rst_instreq", {31'd0, bus.InstReq}, 32'd0);
        check_output("rst_pc", {16'd0, bus.PC}, 32'd0);
        check_output("rst_en", {31'd0, bus.En}, 32'd0);
        check_output("rst_rdest", {28'd0, bus.RdestRegLoc}, 32'd0);
        check_output("rst_rsrc", {28'd0, bus.RsrcRegLoc}, 32'd0);
        check_output("rst_opcode", {27'd0, bus.OpCode}, 32'd0);
        check_output("rst_imm", {16'd0, bus.Imm}, 32'd0);
        check_output("rst_imm_s", {31'd0, bus.Imm_s}, 32'd0);
        check_output("rst_flag_reg", {27'd0, bus.FlagReg}, 32'd0);
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            check_output("idle_instreq", {31'd0, bus.InstReq}, 32'd1);
            check_output("idle_pc", {16'd0, bus.PC}, 32'd0);
        end

        //             inst      flags     w  ab pc        next      rd    rs    ck op        imm       s  en fa
        apply_stimulus(16'h0352, 5'b00001, 0, 0, 16'h0000, 16'h0001, 4'h3, 4'h2, 1, 5'b00101, 16'h0052, 0, 1, 5'b00001);
        apply_stimulus(16'h54F6, 5'b10100, 2, 0, 16'h0001, 16'h0002, 4'h4, 4'h6, 1, 5'b00101, 16'hFFF6, 1, 1, 5'b10100);
        apply_stimulus(16'hB4F6, 5'b01000, 0, 0, 16'h0002, 16'h0003, 4'h4, 4'h6, 1, 5'b01011, 16'hFFF6, 1, 0, 5'b01000);
        apply_stimulus(16'h01B2, 5'b01001, 0, 0, 16'h0003, 16'h0004, 4'h1, 4'h2, 1, 5'b01011, 16'hFFB2, 0, 0, 5'b01001);
        apply_stimulus(16'hCE06, 5'b11111, 0, 0, 16'h0004, 16'h000A, 4'hE, 4'h6, 1, 5'b00000, 16'h0006, 0, 0, 5'b01001);
        apply_stimulus(16'hC0FC, 5'b00000, 0, 0, 16'h000A, 16'h0006, 4'h0, 4'hC, 1, 5'b00000, 16'hFFFC, 0, 0, 5'b01001);
        apply_stimulus(16'hB000, 5'b00000, 0, 0, 16'h0006, 16'h0007, 4'h0, 4'h0, 1, 5'b01011, 16'h0000, 1, 0, 5'b00000);
        apply_stimulus(16'hCE03, 5'b10000, 0, 0, 16'h0007, 16'h000A, 4'hE, 4'h3, 1, 5'b00000, 16'h0003, 0, 0, 5'b00000);
        apply_stimulus(16'hC0FC, 5'b01000, 0, 0, 16'h000A, 16'h000B, 4'h0, 4'hC, 1, 5'b00000, 16'hFFFC, 0, 0, 5'b00000);
        apply_stimulus(16'hC1F5, 5'b00000, 0, 0, 16'h000B, 16'h0000, 4'h1, 4'h5, 1, 5'b00000, 16'hFFF5, 0, 0, 5'b00000);
        apply_stimulus(16'hC7FF, 5'b11111, 0, 0, 16'h0000, 16'h0001, 4'h7, 4'hF, 1, 5'b00000, 16'hFFFF, 0, 0, 5'b00000);
        apply_stimulus(16'hCEFE, 5'b00000, 0, 0, 16'h0001, 16'hFFFF, 4'hE, 4'hE, 1, 5'b00000, 16'hFFFE, 0, 0, 5'b00000);
        apply_stimulus(16'hF000, 5'b11111, 0, 0, 16'hFFFF, 16'h0000, 4'h0, 4'h0, 0, 5'b00000, 16'h0000, 0, 0, 5'b00000);
        apply_stimulus(16'h0123, 5'b11111, 0, 1, 16'h0000, 16'h0000, 4'h1, 4'h3, 1, 5'b00010, 16'h0023, 0, 0, 5'b00000);
        apply_stimulus(16'h1380, 5'b10000, 0, 0, 16'h0000, 16'h0001, 4'h3, 4'h0, 1, 5'b00001, 16'hFF80, 1, 1, 5'b10000);
        apply_stimulus(16'hC610, 5'b00000, 0, 0, 16'h0001, 16'h0011, 4'h6, 4'h0, 1, 5'b00000, 16'h0010, 0, 0, 5'b10000);
        apply_stimulus(16'hC210, 5'b00001, 0, 0, 16'h0011, 16'h0012, 4'h2, 4'h0, 1, 5'b00000, 16'h0010, 0, 0, 5'b10000);
        apply_stimulus(16'hD5A7, 5'b00000, 0, 0, 16'h0012, 16'h0013, 4'h5, 4'h7, 0, 5'b00000, 16'hFFA7, 0, 0, 5'b10000);
        apply_stimulus(16'h0A4C, 5'b00100, 1, 0, 16'h0013, 16'h0014, 4'hA, 4'hC, 1, 5'b00100, 16'h004C, 0, 1, 5'b00100);

        repeat (3) begin
            @(posedge Clk); #1;
        end
        check_output("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef CTRL_RETIRE_CNT_EN
        check_output("retire_cnt", {16'd0, RetireCnt}, retire_exp);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        check_output("retire_cnt_rst", {16'd0, RetireCnt}, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
